// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU result types and op-select encodings
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic OP_AND = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic                 sel;
    logic                 zero;
  } alu_entry_t;

endpackage

// File: rtl/alu_fifo_mem.sv
// rtl/alu_fifo_mem.sv - entry storage, one synchronous write port, one asynchronous read port
module alu_fifo_mem #(
  parameter int DW    = 6,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // No reset on the array; validity is tracked entirely by the top's count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - valid/ready FIFO buffering ALU mux results with op tag and zero flag
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_sel,
  output logic                     out_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 2;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;
  logic          push;
  logic          pop;

  // Full refuses writes even when the head leaves this cycle: no write-through path.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign wr_data = {in_result, in_sel, (in_result == '0)};

  alu_fifo_mem #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push && !flush),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign out_result = out_valid ? rd_data[EW-1:2] : '0;
  assign out_sel    = out_valid ? rd_data[1]      : 1'b0;
  assign out_zero   = out_valid ? rd_data[0]      : 1'b0;

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - randomized and directed self-checking bench for alu_result_fifo
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [WIDTH-1:0] in_result;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_sel;
  logic             out_zero;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;

  alu_entry_t model_q[$];
  logic [4:0] popped[$];

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge: drive, compare against the queue model, clock once, update model.
  task automatic cycle(input logic v, input logic [3:0] r, input logic s,
                       input logic ordy, input logic fl);
    int  n;
    bit  mpush;
    bit  mpop;
    n = model_q.size();
    in_valid  = v;
    in_result = r;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    #1;
    check("count", 32'(count), 32'(n));
    check("in_ready", 32'(in_ready), 32'(n < DEPTH));
    check("out_valid", 32'(out_valid), 32'(n > 0));
    if (n > 0) begin
      check("out_result", 32'(out_result), 32'(model_q[0].result));
      check("out_sel", 32'(out_sel), 32'(model_q[0].sel));
      check("out_zero", 32'(out_zero), 32'(model_q[0].result == 4'h0));
    end else begin
      check("idle_result", 32'(out_result), 32'(0));
      check("idle_sel", 32'(out_sel), 32'(0));
      check("idle_zero", 32'(out_zero), 32'(0));
    end
    mpush = v && (n < DEPTH);
    mpop  = ordy && (n > 0);
    if (mpop && !fl) popped.push_back({out_sel, out_result});
    @(posedge clk);
    #1;
    if (fl) begin
      model_q.delete();
    end else begin
      if (mpop) void'(model_q.pop_front());
      if (mpush) model_q.push_back(alu_entry_t'{result: r, sel: s, zero: (r == 4'h0)});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] fill_exp [4];
    logic [3:0] v4;
    fill_exp = '{5'h03, 5'h10, 5'h1F, 5'h08};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_sel = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_result", 32'(out_result), 32'(0));
    rst_n = 1'b1;
    cycle(1'b0, 4'h0, OP_AND, 1'b1, 1'b0);
    check("empty_pop_count", 32'(count), 32'(0));

    cycle(1'b1, 4'h3, OP_AND, 1'b0, 1'b0);
    cycle(1'b1, 4'h0, OP_ADD, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, OP_ADD, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, OP_AND, 1'b0, 1'b0);
    check("fill_count", 32'(count), 32'(4));
    check("fill_in_ready", 32'(in_ready), 32'(0));
    cycle(1'b1, 4'h5, OP_AND, 1'b0, 1'b0);
    check("overflow_count", 32'(count), 32'(4));
    popped.delete();
    repeat (5) cycle(1'b0, 4'h0, OP_AND, 1'b1, 1'b0);
    check("drain_len", 32'(popped.size()), 32'(4));
    for (int i = 0; i < 4 && i < popped.size(); i++) check("drain_entry", 32'(popped[i]), 32'(fill_exp[i]));

    popped.delete();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) check("wrap_count", 32'(count), 32'(1));
      v4 = 4'(i);
      cycle(1'b1, v4, v4[0], 1'b1, 1'b0);
    end
    cycle(1'b0, 4'h0, OP_AND, 1'b1, 1'b0);
    check("wrap_len", 32'(popped.size()), 32'(10));
    for (int i = 0; i < 10 && i < popped.size(); i++) begin
      v4 = 4'(i);
      check("wrap_entry", 32'(popped[i]), 32'({v4[0], v4}));
    end

    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), OP_ADD, 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'(0));
    cycle(1'b1, 4'hA, OP_ADD, 1'b1, 1'b0);
    check("full_pop_count", 32'(count), 32'(3));
    check("full_pop_head", 32'(out_result), 32'(2));
    repeat (3) cycle(1'b0, 4'h0, OP_AND, 1'b1, 1'b0);

    cycle(1'b1, 4'h6, OP_AND, 1'b0, 1'b0);
    cycle(1'b1, 4'h7, OP_ADD, 1'b0, 1'b0);
    cycle(1'b1, 4'h9, OP_ADD, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'(0));
    check("flush_out_valid", 32'(out_valid), 32'(0));
    popped.delete();
    cycle(1'b1, 4'hC, OP_AND, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 4'h0, OP_AND, 1'b1, 1'b0);
    check("flush_len", 32'(popped.size()), 32'(1));
    if (popped.size() > 0) check("flush_entry", 32'(popped[0]), 32'(5'h0C));

    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), OP_AND, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_count", 32'(count), 32'(0));
    check("arst_in_ready", 32'(in_ready), 32'(1));
    check("arst_out_result", 32'(out_result), 32'(0));
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Buffers results from the ALU 2:1 result mux for the next datapath stage. Each entry holds:
- the WIDTH-bit mux output;
- the select bit that produced it (0 = AND, 1 = ADD);
- a zero flag computed at write time.

Both sides use a valid/ready handshake, so the ALU can produce results back-to-back while the consumer (register-file write-back) stalls.

## Interface
Parameters:
- WIDTH, 4, result width; must match the mux output width.
- DEPTH, 4, number of entries; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_result  input  WIDTH  result from the ALU mux.
- in_sel  input  1  mux select that produced in_result.
- in_valid  input  1  producer has a result this cycle.
- in_ready  output  1  FIFO accepts a write this cycle.
- out_result  output  WIDTH  head-entry result.
- out_sel  output  1  head-entry op tag.
- out_zero  output  1  head-entry zero flag (result == 0).
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer takes the head this cycle.
- count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- Push: occurs when in_valid && in_ready at the rising edge. Writes {in_result, in_sel, in_result==0} to mem[wr_ptr], then wr_ptr increments.
- Pop: occurs when out_valid && out_ready at the rising edge. rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special case.
- Count:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no write-through when full. When full, a pop in the same cycle does not admit a push.
- out_valid = (count != 0). An empty FIFO never pops.
- out_result, out_sel and out_zero show mem[rd_ptr] when out_valid = 1, and are forced to 0 when out_valid = 0.
- flush = 1:
  - at the next edge, pointers and count go to 0;
  - a push or pop in that same cycle is discarded;
  - memory contents are not cleared.
- Producer rule: once in_valid is asserted, the producer holds it and its data stable until accepted. The FIFO does not check this.
- Reset (rst_n low, any time including mid-transfer):
  - pointers = 0, count = 0;
  - in_ready = 1, out_valid = 0;
  - out_result = 0, out_sel = 0, out_zero = 0.
  - Any entries in flight are lost.
- Memory array has no reset.

## Timing
- Write-to-read latency: 1 cycle. A word pushed at edge N is visible on out_* with out_valid = 1 after edge N; it can be popped at edge N+1.
- Throughput: 1 push and 1 pop per cycle in steady state.
- in_ready, out_valid and count are combinational functions of registered count only. There is no combinational path from in_valid to out_ready or the reverse.
- out_* data are a combinational read of registered memory at rd_ptr. There is no path from in_* to out_* within the same cycle.
- Reset assertion takes effect immediately. Deassertion is synchronized externally; the first push is accepted at the first edge after rst_n goes high.

## Structure
- Shared package alu_pkg:
  - ALU_WIDTH = 4;
  - OP_AND = 1'b0, OP_ADD = 1'b1;
  - packed struct alu_entry_t {result[ALU_WIDTH-1:0], sel, zero}.
- One sub-module, alu_fifo_mem: DEPTH × entry storage with one synchronous write port and one asynchronous read port.
- Pointer, count and handshake logic stay in the top module.

## Test plan
- Reset/empty: hold rst_n = 0, then release. Requires count = 0, in_ready = 1, out_valid = 0, out_result = 0. A pop attempt with out_ready = 1 leaves count at 0.
- Fill/overflow: push 4'h3/AND, 4'h0/ADD, 4'hF/ADD, 4'h8/AND with out_ready = 0. Requires count = 4 and in_ready = 0. A fifth push of 4'h5 must not be accepted. Draining yields 3, 0, F, 8 in order with sel 0, 1, 1, 0 and zero 0, 1, 0, 0.
- Wrap-around: run 10 back-to-back pushes while popping every cycle, with values 0..9 and sel alternating. Requires output order 0..9 in order, count staying at 1 after the first edge, and correct tags across the pointer wrap.
- Full with simultaneous pop: at count = 4, assert in_valid and out_ready together. Requires the pop to occur, the push to be refused (in_ready = 0 that cycle), and count = 3 after the edge.
- Flush collision: at count = 2, assert flush, in_valid and out_ready in the same cycle. Requires count = 0 and out_valid = 0 after the edge, and the flushed and pushed data never to appear.
- Async reset mid-stream: with count = 3, drop rst_n between edges. Requires out_valid = 0, count = 0 and in_ready = 1 immediately, without waiting for a clock edge.
